nvm_serial_writer: RTL
======================

Name: nvm_serial_writer

Overview:
Serial-in, parallel-out write engine for the NVM. It is the counterpart of the NVM serial reader.
- Accepts an MSB-first bit stream framed by `write`.
- Assembles each group of 8 bits into a byte.
- Presents each byte, with its target address, to the NVM array through a one-entry holding register and a valid/ready handshake.
- Lets shifting of the next byte continue while the previous byte is still waiting for the NVM.

Parameters:
- DATA_W, 8, byte width. Also sets the bit-counter terminal value DATA_W-1.
- ADDR_W, 5, NVM address width.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- clr  input  1  synchronous, active-high reset.
- write  input  1  frame enable; a bit is shifted on every cycle it is high.
- Data_in  input  1  serial data bit, MSB first.
- Address_in  input  ADDR_W  start address, sampled at frame start (see Optional Feature).
- nvm_ready  input  1  NVM can accept a write this cycle.
- nvm_we  output  1  write request; high while the holding register is valid.
- nvm_addr  output  ADDR_W  address of the held byte.
- nvm_data  output  DATA_W  held byte.
- busy  output  1  high when state is not S_idle OR the holding register is valid.
- overrun  output  1  sticky flag: a completed byte was dropped.

Behaviour:
- Reset (clr=1 at an edge) dominates every other event, including mid-frame and mid-handshake. After it:
  - state=S_idle, SIPO=0, bit_cnt=0, addr_ptr=0, hold_v=0, hold_addr=0, hold_data=0, overrun=0.
  - Hence nvm_we=0, nvm_addr=0, nvm_data=0, busy=0.
- Shift FSM, 2 states:
  - S_idle, write=0: stay. SIPO and bit_cnt are cleared.
  - S_idle, write=1: go to S_Shift. In this same cycle:
    - addr_ptr <= Address_in.
    - overrun <= 0.
    - SIPO <= {SIPO[DATA_W-2:0], Data_in}, i.e. the first bit is captured.
    - bit_cnt <= 1.
  - S_Shift, write=1: shift one bit, bit_cnt+1.
  - S_Shift, write=0: go to S_idle.
    - Any partial byte (bit_cnt 1..DATA_W-1) is discarded and bit_cnt=0.
    - A valid holding register is not affected and still drains.
- Byte completion: a shift cycle with bit_cnt==DATA_W-1.
  - Completed byte = {SIPO[DATA_W-2:0], Data_in}.
  - bit_cnt wraps to 0.
  - addr_ptr increments modulo 2^ADDR_W (31 -> 0 with defaults).
  - If the holding register is free, or is being drained this same cycle (nvm_we & nvm_ready):
    - hold_data <= completed byte, hold_addr <= current addr_ptr, hold_v <= 1.
    - A simultaneous drain and load gives no gap and no overrun.
  - Otherwise: the byte is dropped, overrun <= 1 (sticky until clr or the next frame start), and addr_ptr still increments.
- Latency: nvm_we rises one clock after the edge that shifts the 8th bit.
- Handshake:
  - nvm_we = hold_v.
  - nvm_addr and nvm_data stay stable while nvm_we is high.
  - A transfer occurs at an edge with nvm_we & nvm_ready, and hold_v then clears unless a new byte loads in the same cycle.
  - nvm_ready while nvm_we=0 is ignored.
- Back-to-back frames: write low for exactly 1 cycle, then high again, starts a new frame with a freshly sampled Address_in. The old held byte is unaffected.
- busy is purely registered state, with no combinational path from the inputs.

Optional Feature:
Macro name: NVM_ADDR_AUTOINC_EN.
- Defined: address handling is exactly as described above. addr_ptr is sampled at frame start and post-increments per completed byte, wrapping at 2^ADDR_W.
- Not defined:
  - There is no pointer; hold_addr <= Address_in is sampled at each byte-completion cycle.
  - Consecutive bytes go to whatever Address_in shows at that moment.
  - All other behaviour is identical.

Test Plan:
1. Single byte, macro on: clr pulse, Address_in=5'd3, write high 8 cycles with bits 1,0,1,1,0,0,1,0, nvm_ready=1.
   -> nvm_we high for exactly 1 cycle, starting one cycle after the 8th bit, with nvm_addr=3 and nvm_data=8'hB2; overrun=0; busy falls after the drain.
2. Two-byte stream with ready held low: 16 bits 8'hA5 then 8'h3C, nvm_ready=0 throughout.
   -> A5 is held at addr 3; 3C is dropped; overrun=1; nvm_data stays A5. Raise nvm_ready -> one transfer, then nvm_we=0.
3. Simultaneous drain and load: nvm_ready=1 only in the cycle the 2nd byte completes.
   -> The 1st byte transfers, the 2nd byte is loaded with no idle cycle, nvm_addr increments 3 -> 4, overrun=0.
4. Abort: write high for 5 bits, then low.
   -> No nvm_we, bit_cnt=0, busy drops the next cycle. The next 8-bit frame yields the correct byte with no residue.
5. Wrap: Address_in=5'd31, three bytes 11, 22, 33 with nvm_ready=1.
   -> Writes go to addresses 31, 0, 1.
6. Reset mid-handshake: nvm_we=1, nvm_ready=0, assert clr for one cycle.
   -> All outputs 0 the next cycle; no transfer counted; overrun cleared.

Source files
------------

// File: rtl/nvm_serial_writer.sv
// nvm_serial_writer: MSB-first serial bit stream to NVM byte writes through a one-entry valid/ready holding register
// Ports: clk, clr (sync active-high reset) | write, Data_in (framed serial input) | Address_in (target address)
//        nvm_ready (sink ready) | nvm_we, nvm_addr, nvm_data (held write) | busy (shift or hold pending) | overrun (sticky drop)
// Macro NVM_ADDR_AUTOINC_EN: address sampled at frame start and post-incremented per byte; otherwise Address_in sampled per byte.
module nvm_serial_writer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              write,
  input  logic              Data_in,
  input  logic [ADDR_W-1:0] Address_in,
  input  logic              nvm_ready,
  output logic              nvm_we,
  output logic [ADDR_W-1:0] nvm_addr,
  output logic [DATA_W-1:0] nvm_data,
  output logic              busy,
  output logic              overrun
);
  localparam int CNT_W = $clog2(DATA_W);
  typedef enum logic {S_idle, S_Shift} state_t;
  state_t r_state, w_next;
  logic [DATA_W-1:0] r_sipo, r_hold_data, w_byte;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [ADDR_W-1:0] r_hold_addr, w_load_addr;
  logic r_hold_v, r_overrun, w_start, w_done, w_load, w_drain;
`ifdef NVM_ADDR_AUTOINC_EN
  logic [ADDR_W-1:0] r_addr_ptr;
  always_ff @(posedge clk)
    if (clr) r_addr_ptr <= '0;
    else if (w_start) r_addr_ptr <= Address_in;
    else if (w_done) r_addr_ptr <= r_addr_ptr + 1'b1;
  assign w_load_addr = r_addr_ptr;
`else
  assign w_load_addr = Address_in;
`endif
  always_comb begin
    w_next  = write ? S_Shift : S_idle;
    w_start = write && r_state == S_idle;
    w_done  = write && r_state == S_Shift && r_bit_cnt == CNT_W'(DATA_W-1);
    w_byte  = {r_sipo[DATA_W-2:0], Data_in};
    w_drain = r_hold_v && nvm_ready;
    // a drain on the same edge frees the slot, so the new byte loads with no gap
    w_load  = w_done && (!r_hold_v || nvm_ready);
  end
  always_ff @(posedge clk)
    if (clr) begin
      r_state     <= S_idle;
      r_sipo      <= '0;
      r_bit_cnt   <= '0;
      r_hold_v    <= 1'b0;
      r_hold_addr <= '0;
      r_hold_data <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_sipo    <= write ? w_byte : '0;
      r_bit_cnt <= !write ? '0 : w_start ? CNT_W'(1) : w_done ? '0 : r_bit_cnt + 1'b1;
      r_overrun <= w_start ? 1'b0 : (w_done && !w_load) ? 1'b1 : r_overrun;
      if (w_load) begin
        r_hold_v    <= 1'b1;
        r_hold_addr <= w_load_addr;
        r_hold_data <= w_byte;
      end else if (w_drain) r_hold_v <= 1'b0;
    end
  assign nvm_we   = r_hold_v;
  assign nvm_addr = r_hold_addr;
  assign nvm_data = r_hold_data;
  assign busy     = r_state != S_idle || r_hold_v;
  assign overrun  = r_overrun;
endmodule
